pipeline_top: RTL and testbench

PIPELINE_TOP -- requirements
Module: pipeline_top

---
 rtl/pipeline_top.sv | 368 ++++++++++++++++++++++++++++++++++++
 tb/tb_pipeline_top.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_top.sv
// pipeline_top: 28x28 Q8.8 image -> strided 8-tap row/column convolution -> 121-32-10 dense net -> argmax.
// Build option: define PIPE_RELU_EN to clamp the hidden (dense1) layer at zero.

package pipeline_pkg;
  // Q8.8 rescale with saturation to 16 bits; optional clamp at zero.
  function automatic logic signed [15:0] q88_sat(input logic signed [39:0] acc, input logic relu);
    logic signed [39:0] sh;
    logic signed [15:0] res;
    sh = acc >>> 8;
    if (sh > 40'sd32767) res = 16'sh7FFF;
    else if (sh < -40'sd32768) res = 16'sh8000;
    else res = sh[15:0];
    if (relu && res[15]) res = '0;
    return res;
  endfunction
endpackage

// Sequential MAC: walks (out, in) index pairs, accumulates one product per cycle.
// Operands arrive one cycle after their indices are issued (registered RAM reads).
module mac_seq #(
  parameter int N_OUT = 10,
  parameter int N_IN  = 8,
  parameter bit RELU  = 1'b0,
  parameter int OW    = $clog2(N_OUT),
  parameter int IW    = $clog2(N_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  output logic [OW-1:0]        o_out_idx,
  output logic [IW-1:0]        o_in_idx,
  input  logic signed [15:0]   i_a,
  input  logic signed [15:0]   i_b,
  input  logic signed [15:0]   i_bias,
  output logic                 o_wr_en,
  output logic [OW-1:0]        o_wr_idx,
  output logic signed [15:0]   o_wr_data,
  output logic                 o_done
);
  import pipeline_pkg::*;

  logic                r_busy, r_p_vld, r_p_first, r_p_last, r_done;
  logic [OW-1:0]       r_o, r_p_o;
  logic [IW-1:0]       r_i;
  logic signed [39:0]  r_acc;
  logic signed [31:0]  w_prod;
  logic signed [39:0]  w_sum, w_biased;
  logic                w_last_i, w_last_o;

  assign w_last_i = (r_i == IW'(N_IN - 1));
  assign w_last_o = (r_o == OW'(N_OUT - 1));
  assign w_prod   = i_a * i_b;
  assign w_sum    = (r_p_first ? 40'sd0 : r_acc) + 40'(w_prod);
  assign w_biased = w_sum + (40'(i_bias) <<< 8);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_p_vld   <= 1'b0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
      r_done    <= 1'b0;
      r_o       <= '0;
      r_p_o     <= '0;
      r_i       <= '0;
      r_acc     <= '0;
    end else begin
      r_done    <= r_p_vld && r_p_last && (r_p_o == OW'(N_OUT - 1));
      r_p_vld   <= r_busy;
      r_p_first <= (r_i == '0);
      r_p_last  <= w_last_i;
      r_p_o     <= r_o;
      if (i_start) begin
        r_busy <= 1'b1;
        r_o    <= '0;
        r_i    <= '0;
      end else if (r_busy) begin
        if (w_last_i) begin
          r_i <= '0;
          if (w_last_o) r_busy <= 1'b0;
          else          r_o    <= r_o + 1'b1;
        end else begin
          r_i <= r_i + 1'b1;
        end
      end
      if (r_p_vld) r_acc <= w_sum;
    end
  end

  assign o_out_idx = r_o;
  assign o_in_idx  = r_i;
  assign o_wr_en   = r_p_vld && r_p_last;
  assign o_wr_idx  = r_p_o;
  assign o_wr_data = q88_sat(w_biased, RELU);
  assign o_done    = r_done;
endmodule

module row_engine #(
  parameter int IN_LEN = 28,
  parameter int K      = 8,
  parameter int OUT_W  = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [K-1:0][15:0]          i_kernel,
  output logic [OUT_W-1:0][15:0]      o_rc,
  output logic                        o_done
);
  localparam int OW     = $clog2(OUT_W);
  localparam int IW     = $clog2(K);
  localparam int AW     = $clog2(IN_LEN);
  localparam int STRIDE = (IN_LEN - K) / (OUT_W - 1);

  logic signed [15:0]     input_mem [0:IN_LEN-1];
  logic signed [15:0]     r_x, r_w;
  logic [OUT_W-1:0][15:0] r_rc;
  logic [OW-1:0]          w_oi, w_wr_idx;
  logic [IW-1:0]          w_ii;
  logic                   w_wr_en;
  logic signed [15:0]     w_wr_data;

  mac_seq #(.N_OUT(OUT_W), .N_IN(K)) mac_inst (
    .clk(clk), .rst(rst), .i_start(i_start),
    .o_out_idx(w_oi), .o_in_idx(w_ii),
    .i_a(r_x), .i_b(r_w), .i_bias(16'sd0),
    .o_wr_en(w_wr_en), .o_wr_idx(w_wr_idx), .o_wr_data(w_wr_data), .o_done(o_done)
  );

  always_ff @(posedge clk) begin
    r_x <= input_mem[AW'(STRIDE * w_oi + w_ii)];
    r_w <= i_kernel[w_ii];
  end

  always_ff @(posedge clk) begin
    if (rst) r_rc <= '0;
    else if (w_wr_en) r_rc[w_wr_idx] <= w_wr_data;
  end

  assign o_rc = r_rc;
endmodule

module row_block #(
  parameter int IN_LEN = 28,
  parameter int K      = 8,
  parameter int OUT_W  = 11,
  parameter int ROWS   = 28
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [K-1:0][15:0]                 i_kernel,
  output logic [ROWS-1:0][OUT_W-1:0][15:0]   o_rc,
  output logic                               o_done
);
  logic [ROWS-1:0] w_done;

  for (genvar gi = 0; gi < ROWS; gi++) begin : RENG
    row_engine #(.IN_LEN(IN_LEN), .K(K), .OUT_W(OUT_W)) row_engine_inst (
      .clk(clk), .rst(rst), .i_start(i_start), .i_kernel(i_kernel),
      .o_rc(o_rc[gi]), .o_done(w_done[gi])
    );
  end

  assign o_done = &w_done;
endmodule

module dense_layer #(
  parameter int N_IN  = 121,
  parameter int N_OUT = 32,
  parameter bit RELU  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [N_IN-1:0][15:0]   i_x,
  output logic [N_OUT-1:0][15:0]  o_y,
  output logic                    o_done
);
  localparam int OW = $clog2(N_OUT);
  localparam int IW = $clog2(N_IN);

  logic signed [15:0]     weights [N_OUT][N_IN];
  logic signed [15:0]     bias [N_OUT];
  logic signed [15:0]     r_w, r_x, r_b;
  logic [N_OUT-1:0][15:0] r_y;
  logic [OW-1:0]          w_oi, w_wr_idx;
  logic [IW-1:0]          w_ii;
  logic                   w_wr_en;
  logic signed [15:0]     w_wr_data;

  mac_seq #(.N_OUT(N_OUT), .N_IN(N_IN), .RELU(RELU)) mac_inst (
    .clk(clk), .rst(rst), .i_start(i_start),
    .o_out_idx(w_oi), .o_in_idx(w_ii),
    .i_a(r_x), .i_b(r_w), .i_bias(r_b),
    .o_wr_en(w_wr_en), .o_wr_idx(w_wr_idx), .o_wr_data(w_wr_data), .o_done(o_done)
  );

  always_ff @(posedge clk) begin
    r_w <= weights[w_oi][w_ii];
    r_b <= bias[w_oi];
    r_x <= i_x[w_ii];
  end

  always_ff @(posedge clk) begin
    if (rst) r_y <= '0;
    else if (w_wr_en) r_y[w_wr_idx] <= w_wr_data;
  end

  assign o_y = r_y;
endmodule

module pipeline_top #(
  parameter int DATA_W = 16,
  parameter int IN_LEN = 28,
  parameter int K      = 8,
  parameter int OUT_W  = 11,
  parameter int ROWS   = 28,
  parameter int COLS   = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       done,
  output logic [3:0] pred_class
);
  localparam int N_FEAT = OUT_W * COLS;
  localparam int N_HID  = 32;
  localparam int N_CLS  = 10;
  localparam int STRIDE = (IN_LEN - K) / (OUT_W - 1);
  localparam int FW     = $clog2(N_FEAT);
  localparam int KW     = $clog2(K);
  localparam int CIW    = $clog2(OUT_W);
  localparam int CJW    = $clog2(COLS);
  localparam int RW     = $clog2(ROWS);
`ifdef PIPE_RELU_EN
  localparam bit D1_RELU = 1'b1;
`else
  localparam bit D1_RELU = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ROWCONV, S_COLCONV, S_DENSE1, S_DENSE2, S_ARGMAX, S_DONE
  } state_t;

  logic signed [DATA_W-1:0] row_kernel [0:K-1];
  logic signed [DATA_W-1:0] col_kernel [0:K-1];
  logic signed [DATA_W-1:0] dense2_out [0:N_CLS-1];

  state_t                          r_state, w_state_next;
  logic                            w_row_start, w_col_start, w_d1_start, w_d2_start, w_pred_ld;
  logic                            w_row_done, w_col_done, w_d1_done, w_d2_done;
  logic [K-1:0][15:0]              w_row_kern;
  logic [ROWS-1:0][COLS-1:0][15:0] w_rc;
  logic [N_FEAT-1:0][15:0]         r_feat;
  logic [N_HID-1:0][15:0]          w_h;
  logic [N_CLS-1:0][15:0]          w_d2;
  logic signed [15:0]              r_cx, r_cw;
  logic [FW-1:0]                   w_c_oi, w_c_wr_idx;
  logic [KW-1:0]                   w_c_ii;
  logic [CIW-1:0]                  w_ci;
  logic [CJW-1:0]                  w_cj;
  logic [RW-1:0]                   w_crow;
  logic                            w_c_wr_en;
  logic signed [15:0]              w_c_wr_data;
  logic [3:0]                      w_best_idx;
  logic signed [15:0]              w_best_val;

  for (genvar gi = 0; gi < K; gi++) begin : KPACK
    assign w_row_kern[gi] = row_kernel[gi];
  end

  row_block #(.IN_LEN(IN_LEN), .K(K), .OUT_W(COLS), .ROWS(ROWS)) row_block (
    .clk(clk), .rst(rst), .i_start(w_row_start), .i_kernel(w_row_kern),
    .o_rc(w_rc), .o_done(w_row_done)
  );

  // Column pass: output index o = i*COLS + j reads rc[STRIDE*i + k][j].
  mac_seq #(.N_OUT(N_FEAT), .N_IN(K)) col_mac (
    .clk(clk), .rst(rst), .i_start(w_col_start),
    .o_out_idx(w_c_oi), .o_in_idx(w_c_ii),
    .i_a(r_cx), .i_b(r_cw), .i_bias(16'sd0),
    .o_wr_en(w_c_wr_en), .o_wr_idx(w_c_wr_idx), .o_wr_data(w_c_wr_data), .o_done(w_col_done)
  );

  assign w_ci   = CIW'(w_c_oi / COLS);
  assign w_cj   = CJW'(w_c_oi % COLS);
  assign w_crow = RW'(STRIDE * w_ci + w_c_ii);

  always_ff @(posedge clk) begin
    r_cx <= w_rc[w_crow][w_cj];
    r_cw <= col_kernel[w_c_ii];
  end

  always_ff @(posedge clk) begin
    if (rst) r_feat <= '0;
    else if (w_c_wr_en) r_feat[w_c_wr_idx] <= w_c_wr_data;
  end

  dense_layer #(.N_IN(N_FEAT), .N_OUT(N_HID), .RELU(D1_RELU)) dense1 (
    .clk(clk), .rst(rst), .i_start(w_d1_start), .i_x(r_feat), .o_y(w_h), .o_done(w_d1_done)
  );

  dense_layer #(.N_IN(N_HID), .N_OUT(N_CLS), .RELU(1'b0)) dense2 (
    .clk(clk), .rst(rst), .i_start(w_d2_start), .i_x(w_h), .o_y(w_d2), .o_done(w_d2_done)
  );

  for (genvar gi = 0; gi < N_CLS; gi++) begin : D2OUT
    assign dense2_out[gi] = w_d2[gi];
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_best_idx = '0;
    w_best_val = dense2_out[0];
    for (int n = 1; n < N_CLS; n++) begin
      if (dense2_out[n] > w_best_val) begin
        w_best_val = dense2_out[n];
        w_best_idx = 4'(n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      pred_class <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pred_ld) pred_class <= w_best_idx;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_row_start  = 1'b0;
    w_col_start  = 1'b0;
    w_d1_start   = 1'b0;
    w_d2_start   = 1'b0;
    w_pred_ld    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (start) begin
        w_state_next = S_ROWCONV;
        w_row_start  = 1'b1;
      end
      S_ROWCONV: if (w_row_done) begin
        w_state_next = S_COLCONV;
        w_col_start  = 1'b1;
      end
      S_COLCONV: if (w_col_done) begin
        w_state_next = S_DENSE1;
        w_d1_start   = 1'b1;
      end
      S_DENSE1: if (w_d1_done) begin
        w_state_next = S_DENSE2;
        w_d2_start   = 1'b1;
      end
      S_DENSE2: if (w_d2_done) w_state_next = S_ARGMAX;
      S_ARGMAX: begin
        w_pred_ld    = 1'b1;
        w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign done = (r_state == S_DONE);
endmodule

// File: tb/tb_pipeline_top.sv
// Self-checking bench for pipeline_top: backdoor-loaded directed and random inferences
// compared against a plain-arithmetic reference model (honours PIPE_RELU_EN).
module tb_pipeline_top;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       done;
  logic [3:0] pred_class;

  int tests = 0;
  int fails = 0;

  int img [28][28];
  int rk [8];
  int ck [8];
  int w1 [32][121];
  int b1 [32];
  int w2 [10][32];
  int b2 [10];
  int m_rc [28][11];
  int m_f [121];
  int m_h [32];
  int exp_out [10];
  int exp_pred;
  int lat0, lat;
  bit img_load = 1'b0;

  pipeline_top dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .pred_class(pred_class)
  );

  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  for (genvar gi = 0; gi < 28; gi++) begin : LOADI
    always @(posedge img_load)
      for (int c = 0; c < 28; c++) dut.row_block.RENG[gi].row_engine_inst.input_mem[c] = 16'(img[gi][c]);
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int sat16(input longint acc);
    longint s;
    s = acc >>> 8;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  task automatic clear_params();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = 0;
    for (int k = 0; k < 8; k++) begin rk[k] = 0; ck[k] = 0; end
    for (int o = 0; o < 32; o++) begin
      b1[o] = 0;
      for (int i = 0; i < 121; i++) w1[o][i] = 0;
    end
    for (int o = 0; o < 10; o++) begin
      b2[o] = 0;
      for (int i = 0; i < 32; i++) w2[o][i] = 0;
    end
  endtask

  task automatic load_dut();
    for (int k = 0; k < 8; k++) begin
      dut.row_kernel[k] = 16'(rk[k]);
      dut.col_kernel[k] = 16'(ck[k]);
    end
    for (int o = 0; o < 32; o++) begin
      dut.dense1.bias[o] = 16'(b1[o]);
      for (int i = 0; i < 121; i++) dut.dense1.weights[o][i] = 16'(w1[o][i]);
    end
    for (int o = 0; o < 10; o++) begin
      dut.dense2.bias[o] = 16'(b2[o]);
      for (int i = 0; i < 32; i++) dut.dense2.weights[o][i] = 16'(w2[o][i]);
    end
    img_load = 1'b1;
    #1;
    img_load = 1'b0;
    #1;
  endtask

  task automatic model();
    longint acc;
    for (int r = 0; r < 28; r++)
      for (int j = 0; j < 11; j++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(img[r][2*j+k]) * rk[k];
        m_rc[r][j] = sat16(acc);
      end
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < 11; j++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(m_rc[2*i+k][j]) * ck[k];
        m_f[i*11+j] = sat16(acc);
      end
    for (int o = 0; o < 32; o++) begin
      acc = longint'(b1[o]) * 256;
      for (int i = 0; i < 121; i++) acc += longint'(w1[o][i]) * m_f[i];
      m_h[o] = sat16(acc);
`ifdef PIPE_RELU_EN
      if (m_h[o] < 0) m_h[o] = 0;
`endif
    end
    exp_pred = 0;
    for (int o = 0; o < 10; o++) begin
      acc = longint'(b2[o]) * 256;
      for (int i = 0; i < 32; i++) acc += longint'(w2[o][i]) * m_h[i];
      exp_out[o] = sat16(acc);
      if (exp_out[o] > exp_out[exp_pred]) exp_pred = o;
    end
  endtask

  // Starts one inference; optional extra start pulses at cycle offsets p1/p2 while busy.
  task automatic run_inf(input string name, input int p1, input int p2, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_drop"}, int'(done), 0);
    cycles = 1;
    while (!done && cycles < 8000) begin
      start = (cycles == p1 || cycles == p2);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check({name, "_done_in_time"}, int'(done), 1);
    $display("[TB] run %s: latency %0d cycles, pred_class %0d", name, cycles, pred_class);
  endtask

  task automatic check_outputs(input string name);
    for (int n = 0; n < 10; n++)
      check($sformatf("%s_out%0d", name, n), int'(dut.dense2_out[n]), exp_out[n]);
    check({name, "_pred"}, int'(pred_class), exp_pred);
  endtask

  task automatic randomize_params();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = int'($urandom_range(512)) - 256;
    for (int k = 0; k < 8; k++) begin
      rk[k] = int'($urandom_range(256)) - 128;
      ck[k] = int'($urandom_range(256)) - 128;
    end
    for (int o = 0; o < 32; o++) begin
      b1[o] = int'($urandom_range(512)) - 256;
      for (int i = 0; i < 121; i++) w1[o][i] = int'($urandom_range(256)) - 128;
    end
    for (int o = 0; o < 10; o++) begin
      b2[o] = int'($urandom_range(512)) - 256;
      for (int i = 0; i < 32; i++) w2[o][i] = int'($urandom_range(256)) - 128;
    end
  endtask

  initial begin
    clear_params();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_done", int'(done), 0);
    check("reset_pred", int'(pred_class), 0);

    // Zero image, single dense2 bias
    clear_params();
    b2[3] = 'h0100;
    load_dut();
    model();
    run_inf("zero_bias3", -1, -1, lat0);
    check_outputs("zero_bias3");
    check("zero_bias3_out3_const", int'(dut.dense2_out[3]), 'h0100);
    check("zero_bias3_pred_const", int'(pred_class), 3);

    // All-ones image and kernels: each cc = 64.0
    clear_params();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = 'h0100;
    for (int k = 0; k < 8; k++) begin rk[k] = 'h0100; ck[k] = 'h0100; end
    w1[0][0] = 'h0100;
    w2[5][0] = 'h0100;
    load_dut();
    model();
    run_inf("ones", -1, -1, lat);
    check_outputs("ones");
    check("ones_out5_const", int'(dut.dense2_out[5]), 'h4000);
    check("ones_pred_const", int'(pred_class), 5);
    check("ones_latency", lat, lat0);

    // Reset during DENSE1 aborts; restart reproduces the same result
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2000) @(negedge clk);
    check("abort_busy_done", int'(done), 0);
    check("abort_pred_hold", int'(pred_class), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_done", int'(done), 0);
    check("abort_pred", int'(pred_class), 0);
    run_inf("after_abort", -1, -1, lat);
    check_outputs("after_abort");
    check("after_abort_latency", lat, lat0);

    // Equal outputs: tie resolves to index 0
    clear_params();
    for (int o = 0; o < 10; o++) b2[o] = 'h0080;
    load_dut();
    model();
    run_inf("tie", -1, -1, lat);
    check_outputs("tie");
    check("tie_pred_const", int'(pred_class), 0);

    // Negative hidden bias: zero with ReLU, -32.0 without
    clear_params();
    for (int o = 0; o < 32; o++) b1[o] = -'h0100;
    for (int o = 0; o < 10; o++) for (int i = 0; i < 32; i++) w2[o][i] = 'h0100;
    load_dut();
    model();
    run_inf("neg_bias", -1, -1, lat);
    check_outputs("neg_bias");
`ifdef PIPE_RELU_EN
    check("neg_bias_out9_const", int'(dut.dense2_out[9]), 0);
`else
    check("neg_bias_out9_const", int'(dut.dense2_out[9]), -8192);
`endif

    // Large positive values drive every stage into saturation
    clear_params();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = 'h7F00;
    for (int k = 0; k < 8; k++) begin rk[k] = 'h7F00; ck[k] = 'h7F00; end
    for (int o = 0; o < 32; o++) for (int i = 0; i < 121; i++) w1[o][i] = 'h0100;
    for (int o = 0; o < 10; o++) for (int i = 0; i < 32; i++) w2[o][i] = 'h0100;
    load_dut();
    model();
    run_inf("overflow", -1, -1, lat);
    check_outputs("overflow");
    check("overflow_out0_const", int'(dut.dense2_out[0]), 'h7FFF);
    check("overflow_out7_const", int'(dut.dense2_out[7]), 'h7FFF);

    // Random data with start pulses while busy: must not change latency or result
    randomize_params();
    load_dut();
    model();
    run_inf("dbl_start", 100, 3000, lat);
    check_outputs("dbl_start");
    check("dbl_start_latency", lat, lat0);

    for (int t = 0; t < 2; t++) begin
      randomize_params();
      load_dut();
      model();
      run_inf($sformatf("random%0d", t), -1, -1, lat);
      check_outputs($sformatf("random%0d", t));
      check($sformatf("random%0d_latency", t), lat, lat0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
